// File: rtl/recirc_lane_arbiter_if.sv
// Lane-side and downstream-side signals of the recirculation arbiter.
// The master modport drives lanes/config, the slave is the arbiter.
interface recirc_lane_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                  init;
  logic [CNT_WIDTH-1:0]  umbral_alto_in;
  logic [CNT_WIDTH-1:0]  umbral_bajo_in;
  logic [3:0]            fifo_empty;
  logic [DATA_WIDTH-1:0] lane_data0;
  logic [DATA_WIDTH-1:0] lane_data1;
  logic [DATA_WIDTH-1:0] lane_data2;
  logic [DATA_WIDTH-1:0] lane_data3;
  logic [CNT_WIDTH-1:0]  out_fifo_count;
  logic [3:0]            pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  active_out;
  logic                  idle_out;
  logic [4:0]            state;

  modport master (
    output init, umbral_alto_in, umbral_bajo_in,
    output fifo_empty, out_fifo_count,
    output lane_data0, lane_data1, lane_data2, lane_data3,
    input  pop, data_out, valid_out,
    input  active_out, idle_out, state
  );

  modport slave (
    input  init, umbral_alto_in, umbral_bajo_in,
    input  fifo_empty, out_fifo_count,
    input  lane_data0, lane_data1, lane_data2, lane_data3,
    output pop, data_out, valid_out,
    output active_out, idle_out, state
  );
endinterface

// File: rtl/recirc_lane_arbiter.sv
// Round-robin pop scheduler for four lane FIFOs onto one recirc path,
// with high/low occupancy hysteresis on the downstream FIFO.
module recirc_lane_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter logic [CNT_WIDTH-1:0] HIGH_DEF = 12,
  parameter logic [CNT_WIDTH-1:0] LOW_DEF  = 4
) (
  input logic clk,
  input logic reset_L,
  recirc_lane_arbiter_if.slave bus
);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_PAUSE  = 5'b10000
  } state_t;

  state_t                st;
  logic [CNT_WIDTH-1:0]  alto;
  logic [CNT_WIDTH-1:0]  bajo;
  logic [1:0]            ptr;
  logic [1:0]            tag;
  logic                  pend;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;

  logic                  any;
  logic                  hi;
  logic                  lo;
  logic [3:0]            gnt;
  logic [1:0]            glane;
  logic                  found;
  logic [1:0]            cand;
  logic [DATA_WIDTH-1:0] lane_mux;

  assign any = ~&bus.fifo_empty;
  assign hi  = bus.out_fifo_count >= alto;
  assign lo  = bus.out_fifo_count <= bajo;

  // Search starts one past the last granted lane; offset 4 wraps to ptr.
  always_comb begin
    gnt   = '0;
    glane = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && !bus.fifo_empty[cand]) begin
        found = 1'b1;
        glane = cand;
      end
    end
    if (st == S_ACTIVE && !hi && found)
      gnt[glane] = 1'b1;
  end

  always_comb begin
    lane_mux = bus.lane_data0;
    unique case (tag)
      2'd0: lane_mux = bus.lane_data0;
      2'd1: lane_mux = bus.lane_data1;
      2'd2: lane_mux = bus.lane_data2;
      2'd3: lane_mux = bus.lane_data3;
      default: lane_mux = bus.lane_data0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st    <= S_RESET;
      alto  <= HIGH_DEF;
      bajo  <= LOW_DEF;
      ptr   <= 2'd3;
      tag   <= 2'd0;
      pend  <= 1'b0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      // Issued pops always drain, whatever the FSM does next.
      pend  <= |gnt;
      valid <= pend;
      if (|gnt) begin
        tag <= glane;
        ptr <= glane;
      end
      if (pend)
        dout <= lane_mux;
      unique case (st)
        S_RESET: st <= S_INIT;
        S_INIT: begin
          if (bus.init) begin
            alto <= bus.umbral_alto_in;
            bajo <= bus.umbral_bajo_in;
          end else begin
            st <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (bus.init)
            st <= S_INIT;
          else if (any && !hi)
            st <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (hi)
            st <= S_PAUSE;
          else if (!any)
            st <= S_IDLE;
        end
        S_PAUSE: begin
          if (lo)
            st <= any ? S_ACTIVE : S_IDLE;
        end
        default: st <= S_RESET;
      endcase
    end
  end

  assign bus.pop        = gnt;
  assign bus.data_out   = dout;
  assign bus.valid_out  = valid;
  assign bus.active_out = (st == S_ACTIVE);
  assign bus.idle_out   = (st == S_IDLE);
  assign bus.state      = st;

endmodule

// File: doc/recirc_lane_arbiter.md
Name: recirc_lane_arbiter

Overview:
- Round-robin scheduler that shares one downstream recirculation path between four 8-bit lane FIFOs of the PCIe physical-layer datapath.
- Issues at most one pop per cycle to the lane FIFOs and forwards the popped byte with a valid flag toward the lane demuxes.
- Applies hysteresis backpressure from the downstream FIFO occupancy, using high/low thresholds loaded during an INIT state.

Parameters:
- DATA_WIDTH, 8, lane data width.
- CNT_WIDTH, 4, width of downstream occupancy count and thresholds.
- HIGH_DEF, 12, umbral_alto reset value.
- LOW_DEF, 4, umbral_bajo reset value.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  request threshold (re)configuration.
- umbral_alto_in  in  CNT_WIDTH  high threshold, captured in INIT.
- umbral_bajo_in  in  CNT_WIDTH  low threshold, captured in INIT.
- fifo_empty  in  4  per-lane FIFO empty flags; bit i = lane i.
- lane_data0..lane_data3  in  DATA_WIDTH each  FIFO read data; valid the cycle after that lane's pop.
- out_fifo_count  in  CNT_WIDTH  downstream FIFO occupancy.
- pop  out  4  one-hot pop strobes (or 0).
- data_out  out  DATA_WIDTH  forwarded byte.
- valid_out  out  1  data_out valid.
- active_out  out  1  high in ACTIVE.
- idle_out  out  1  high in IDLE.
- state  out  5  one-hot FSM state.

Behaviour:
- Reset, asynchronous while reset_L=0:
  - state=RESET (00001).
  - pop, data_out, valid_out, active_out, idle_out = 0.
  - Thresholds = HIGH_DEF/LOW_DEF.
  - Round-robin pointer = 3, so lane 0 is checked first.
  - In-flight tag cleared.
- States: RESET 00001, INIT 00010, IDLE 00100, ACTIVE 01000, PAUSE 10000.
- Transitions:
  - RESET -> INIT on the first clock with reset_L=1.
  - INIT: captures both thresholds every cycle while init=1; -> IDLE on the first cycle with init=0.
  - IDLE: init=1 -> INIT (priority). Otherwise any lane non-empty and out_fifo_count<umbral_alto -> ACTIVE. Otherwise stay.
  - ACTIVE:
    - out_fifo_count>=umbral_alto -> PAUSE; no pop that cycle.
    - All lanes empty -> IDLE.
    - Otherwise stay and grant.
  - PAUSE: out_fifo_count<=umbral_bajo -> ACTIVE if any lane non-empty, else IDLE. init is ignored.
- Grant, combinational in ACTIVE with no pause condition:
  - Select the first non-empty lane searching pointer+1, +2, +3, +4 (mod 4); assert its pop bit.
  - Pointer updates to the granted lane on that edge.
  - pop=0 in every other state and when all lanes are empty.
- Datapath latency:
  - Pop in cycle N registers lane tag + pending flag at the edge ending N.
  - In N+1, lane_data[tag] is registered to data_out, and valid_out=1 from N+2.
  - With no pending, valid_out=0 and data_out holds its last value.
  - Back-to-back pops give one byte per cycle, in grant order.
- Pops already issued always complete, even if the FSM enters PAUSE/IDLE.
  - Downstream may receive up to 2 bytes after count>=umbral_alto; umbral_alto must be <= 2^CNT_WIDTH-3.
- fifo_empty must reflect a pop by the following cycle. A single-entry lane is granted once, then skipped.
- umbral_bajo>=umbral_alto is illegal configuration; behaviour is unspecified but must not lock up: PAUSE exits when count<=umbral_bajo.
- Reset mid-transfer discards the pending byte; valid_out drops immediately (asynchronous).
- active_out/idle_out are decoded directly from state.

Test Plan:
- Reset then init=1 one cycle with alto=10, bajo=3, then init=0 -> states RESET→INIT→IDLE; thresholds 10/3; all outputs 0.
- All four lanes non-empty, count=0 -> pop sequence 0001,0010,0100,1000,0001; data_out returns lane bytes (A0,B1,C2,D3) two cycles after each pop, valid_out continuous.
- Only lanes 1 and 3 non-empty, pointer at 1 -> grants alternate 3,1,3; lanes 0/2 never popped.
- Streaming with count rising to 10 -> state→PAUSE, pop=0 same cycle, ≤2 trailing valid bytes; count falls to 4 → stays PAUSE; count=3 → ACTIVE, pops resume at next lane in rotation.
- Lane 2 holds a single word (empty goes 1 next cycle) -> exactly one pop on lane 2, state ACTIVE→IDLE, idle_out=1, valid_out one pulse.
- reset_L low one cycle after a pop -> valid_out never asserts; state=RESET asynchronously; after release, pointer restarts at lane 0.
